// File: rtl/genius_seq_store.sv
// genius_seq_store
//   Pattern store and playback engine for the Genius game. A free-running
//   16-bit LFSR supplies a random colour whenever the sequence is extended;
//   the stored sequence is replayed over a valid/ready handshake, and a
//   combinational read port lets the input checker look at any entry.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   new_game     clear sequence, reseed LFSR from the cycle counter, abort playback
//   extend       append one random colour (IDLE only, when not full)
//   play_start   start playback (IDLE only); empty sequence yields an immediate done
//   out_valid    playback colour valid
//   out_ready    driver accepts the current colour
//   out_color    one-hot playback colour
//   playing      high while playback is in progress
//   done         one-cycle pulse at the end of playback
//   rd_addr      checker read address
//   rd_color     one-hot colour at rd_addr, zero beyond the stored length
//   length       number of stored entries, 0..DEPTH
//   full         length == DEPTH
module genius_seq_store #(
  parameter int          DEPTH  = 16,
  parameter int          COLORS = 4,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       new_game,
  input  logic                       extend,
  input  logic                       play_start,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COLORS-1:0]          out_color,
  output logic                       playing,
  output logic                       done,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [COLORS-1:0]          rd_color,
  output logic [$clog2(DEPTH):0]     length,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(COLORS);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t              state;
  logic [15:0]         lfsr;
  logic [15:0]         cnt;
  logic [AW-1:0]       ptr;
  logic [COLORS-1:0]   mem [DEPTH];

  logic                ext_ok;
  logic [COLORS-1:0]   new_color;
  logic [15:0]         reseed;

  function automatic logic [COLORS-1:0] onehot(input logic [CW-1:0] idx);
    logic [COLORS-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    // Fibonacci form, taps 16,14,13,11 (bits 15,13,12,10)
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  assign new_color = onehot(lfsr[CW-1:0]);
  // Seeding from the cycle counter makes the sequence depend on when the
  // player pressed start; an all-zero result would lock the LFSR up.
  assign reseed    = ((cnt ^ SEED) == 16'h0) ? SEED : (cnt ^ SEED);
  assign full      = (length == (AW+1)'(DEPTH));
  assign playing   = (state == PLAY);
  assign ext_ok    = extend && !new_game && !play_start && (state == IDLE) && !full;
  assign rd_color  = ({1'b0, rd_addr} < length) ? mem[rd_addr] : '0;

  // Sequence storage: contents are never cleared, length alone gates visibility
  always_ff @(posedge clk) begin
    if (ext_ok)
      mem[length[AW-1:0]] <= new_color;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr      <= SEED;
      cnt       <= 16'h0;
      state     <= IDLE;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_color <= '0;
      done      <= 1'b0;
      length    <= '0;
    end else begin
      cnt  <= cnt + 16'h1;
      done <= 1'b0;
      if (new_game) begin
        lfsr      <= reseed;
        length    <= '0;
        state     <= IDLE;
        out_valid <= 1'b0;
        out_color <= '0;
      end else begin
        lfsr <= lfsr_next(lfsr);
        case (state)
          IDLE: begin
            if (play_start) begin
              if (length != '0) begin
                state     <= PLAY;
                ptr       <= '0;
                out_valid <= 1'b1;
                out_color <= mem[0];
              end else begin
                done <= 1'b1;
              end
            end else if (ext_ok) begin
              length <= length + 1'b1;
            end
          end
          PLAY: begin
            if (out_valid && out_ready) begin
              if ({1'b0, ptr} == length - 1'b1) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_color <= '0;
                done      <= 1'b1;
              end else begin
                ptr       <= ptr + 1'b1;
                out_color <= mem[ptr + 1'b1];
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_genius_seq_store.sv
// tb_genius_seq_store
//   Directed bench for genius_seq_store (DEPTH=16, COLORS=4, SEED=16'hACE1).
//   A cycle-accurate LFSR/counter reference supplies the expected colours;
//   control behaviour comes from a table of per-cycle vectors plus a few
//   hand-written multi-cycle sequences.
module tb_genius_seq_store;

  localparam int          DEPTH  = 16;
  localparam int          COLORS = 4;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        new_game = 1'b0;
  logic        extend = 1'b0;
  logic        play_start = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [3:0]  out_color;
  logic        playing;
  logic        done;
  logic [3:0]  rd_addr = 4'd0;
  logic [3:0]  rd_color;
  logic [4:0]  length;
  logic        full;

  genius_seq_store #(.DEPTH(DEPTH), .COLORS(COLORS), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .extend(extend),
    .play_start(play_start), .out_valid(out_valid), .out_ready(out_ready),
    .out_color(out_color), .playing(playing), .done(done),
    .rd_addr(rd_addr), .rd_color(rd_color), .length(length), .full(full)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference LFSR and cycle counter
  logic [15:0] m_lfsr, m_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr <= SEED;
      m_cnt  <= 16'h0;
    end else begin
      m_cnt <= m_cnt + 16'h1;
      if (new_game)
        m_lfsr <= ((m_cnt ^ SEED) == 16'h0) ? SEED : (m_cnt ^ SEED);
      else
        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  function automatic logic [3:0] col_now();
    return 4'b0001 << m_lfsr[1:0];
  endfunction

  logic [3:0] expq[$];
  logic [3:0] last_col;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then sample just after the rising edge
  task automatic step(input logic ng, input logic ext, input logic ps, input logic rdy);
    @(negedge clk);
    new_game   = ng;
    extend     = ext;
    play_start = ps;
    out_ready  = rdy;
    last_col   = col_now();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rd(input string name, input int n);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = 4'(a);
      #1;
      chk($sformatf("%s_rd%0d", name, a), rd_color, (a < n) ? expq[a] : 4'h0);
    end
  endtask

  typedef struct {
    logic ng, ext, ps, rdy;
    logic v, pl, dn;
    int   len;
    int   cidx;   // index into expq for out_color; -1 means out_color must be 0
  } vec_t;

  function automatic vec_t mk(logic ng, logic ext, logic ps, logic rdy,
                              logic v, logic pl, logic dn, int len, int cidx);
    vec_t r;
    r.ng = ng; r.ext = ext; r.ps = ps; r.rdy = rdy;
    r.v = v; r.pl = pl; r.dn = dn; r.len = len; r.cidx = cidx;
    return r;
  endfunction

  vec_t tbl[19];

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, %0d checks done", tests);
    $fatal(1, "timeout");
  end

  initial begin
    int prev_len;
    //               ng ext ps rdy  v  pl dn len cidx
    tbl[0]  = mk(0, 0, 1, 0,  0, 0, 1, 0, -1); // play with empty sequence: done only
    tbl[1]  = mk(0, 0, 0, 0,  0, 0, 0, 0, -1);
    tbl[2]  = mk(0, 1, 0, 0,  0, 0, 0, 1, -1);
    tbl[3]  = mk(0, 1, 0, 0,  0, 0, 0, 2, -1);
    tbl[4]  = mk(0, 1, 0, 0,  0, 0, 0, 3, -1);
    tbl[5]  = mk(0, 1, 1, 1,  1, 1, 0, 3,  0); // extend with play_start dropped
    tbl[6]  = mk(0, 1, 0, 1,  1, 1, 0, 3,  1); // extend during PLAY dropped
    tbl[7]  = mk(0, 0, 0, 1,  1, 1, 0, 3,  2);
    tbl[8]  = mk(0, 0, 0, 1,  0, 0, 1, 3, -1);
    tbl[9]  = mk(0, 0, 0, 0,  0, 0, 0, 3, -1);
    tbl[10] = mk(0, 0, 1, 1,  1, 1, 0, 3,  0);
    tbl[11] = mk(0, 0, 0, 1,  1, 1, 0, 3,  1);
    tbl[12] = mk(0, 0, 0, 1,  1, 1, 0, 3,  2);
    tbl[13] = mk(0, 0, 0, 1,  0, 0, 1, 3, -1);
    tbl[14] = mk(0, 0, 1, 0,  1, 1, 0, 3,  0);
    tbl[15] = mk(0, 0, 1, 1,  1, 1, 0, 3,  1); // play_start during PLAY ignored
    tbl[16] = mk(0, 0, 1, 1,  1, 1, 0, 3,  2);
    tbl[17] = mk(0, 0, 0, 1,  0, 0, 1, 3, -1);
    tbl[18] = mk(0, 0, 0, 0,  0, 0, 0, 3, -1);

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_color", out_color, 0);
    chk("rst_playing", playing, 0);
    chk("rst_done", done, 0);
    chk("rst_length", length, 0);
    chk("rst_full", full, 0);
    chk("rst_rd", rd_color, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven control sequence
    prev_len = 0;
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].ng, tbl[i].ext, tbl[i].ps, tbl[i].rdy);
      if (tbl[i].len > prev_len) expq.push_back(last_col);
      prev_len = tbl[i].len;
      chk($sformatf("v%0d_valid", i), out_valid, tbl[i].v);
      chk($sformatf("v%0d_playing", i), playing, tbl[i].pl);
      chk($sformatf("v%0d_done", i), done, tbl[i].dn);
      chk($sformatf("v%0d_length", i), length, tbl[i].len);
      chk($sformatf("v%0d_color", i), out_color, (tbl[i].cidx >= 0) ? expq[tbl[i].cidx] : 4'h0);
    end
    step(0, 0, 0, 0);

    // Read port after three extends
    chk_rd("three", 3);

    // Backpressure: stall 5 cycles on the second colour
    step(0, 0, 1, 1);
    chk("bp_first", out_color, expq[0]);
    step(0, 0, 0, 1);
    chk("bp_second", out_color, expq[1]);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 0);
      chk($sformatf("bp_hold_valid%0d", k), out_valid, 1);
      chk($sformatf("bp_hold_color%0d", k), out_color, expq[1]);
      chk($sformatf("bp_hold_done%0d", k), done, 0);
    end
    step(0, 0, 0, 1);
    chk("bp_third", out_color, expq[2]);
    chk("bp_third_valid", out_valid, 1);
    step(0, 0, 0, 1);
    chk("bp_end_valid", out_valid, 0);
    chk("bp_end_done", done, 1);
    step(0, 0, 0, 0);
    chk("bp_done_width", done, 0);

    // Fill to DEPTH, then one more extend that must be dropped
    for (int k = 0; k < 13; k++) begin
      step(0, 1, 0, 0);
      expq.push_back(last_col);
    end
    chk("fill_len16", length, 16);
    chk("fill_full", full, 1);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("over_len", length, 16);
    chk("over_full", full, 1);
    chk_rd("fill", 16);

    // new_game at the second colour of a playback
    step(0, 0, 1, 1);
    chk("ng_first", out_color, expq[0]);
    step(0, 0, 0, 1);
    chk("ng_second", out_color, expq[1]);
    step(1, 0, 0, 1);
    chk("ng_valid", out_valid, 0);
    chk("ng_playing", playing, 0);
    chk("ng_length", length, 0);
    chk("ng_full", full, 0);
    chk("ng_done", done, 0);
    step(0, 0, 0, 0);
    chk("ng_done_after", done, 0);
    expq.delete();
    chk_rd("ng", 0);

    // new_game exactly when cnt == SEED: reseed must fall back to SEED
    for (int k = 0; k < 70000 && m_cnt != SEED - 16'h1; k++) @(negedge clk);
    chk("cnt_reach", m_cnt, SEED - 16'h1);
    step(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0);
      expq.push_back(last_col);
    end
    step(0, 0, 0, 0);
    chk("seed_len", length, 3);
    chk("seed_first", expq[0], 4'b0010);
    chk_rd("seed", 3);

    // Asynchronous reset in the middle of playback
    step(0, 0, 1, 0);
    chk("rstmid_playing_before", playing, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_valid", out_valid, 0);
    chk("rstmid_color", out_color, 0);
    chk("rstmid_playing", playing, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_length", length, 0);
    chk("rstmid_rd", rd_color, 0);
    @(negedge clk);
    rst = 1'b0;
    new_game = 1'b0; extend = 1'b0; play_start = 1'b0; out_ready = 1'b0;
    step(0, 0, 0, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
